// File: rtl/approx_mult_pipe_cfg.sv
// approx_mult_pipe_cfg: three-stage pipelined approximate multiplier with per-beat
// quadrant approximation modes, ADD/OR recombination and an on-line error monitor.
module approx_mult_pipe_cfg #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [8:0]         in_cfg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic [2*WIDTH-1:0] out_err,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_cnt,
  output logic [2*WIDTH-1:0] stat_max,
  output logic [SUM_W-1:0]   stat_sum
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int EW = ((SUM_W > PW) ? SUM_W : PW) + 1;
  localparam logic [2*H-1:0] TMASK =
    (TRUNC >= 2 * H) ? {(2*H){1'b0}} : ({(2*H){1'b1}} << TRUNC);
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One half-by-half partial product under the selected approximation mode.
  function automatic logic [2*H-1:0] quad(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic [1:0]   mode);
    logic [2*H-1:0] xe;
    logic [2*H-1:0] ye;
    logic [2*H-1:0] p;
    xe = {{H{1'b0}}, x};
    ye = {{H{1'b0}}, y};
    case (mode)
      2'b00:   p = xe * ye;
      2'b01:   p = (xe * ye) & TMASK;
      2'b10:   p = {xe[2*H-1:1], 1'b0} * {ye[2*H-1:1], 1'b0};
      2'b11:   p = {(2*H){1'b0}};
      default: p = {(2*H){1'b0}};
    endcase
    return p;
  endfunction

  logic             v1_r, v2_r, v3_r;
  logic [WIDTH-1:0] a1_r, b1_r;
  logic [8:0]       cfg1_r;
  logic [2*H-1:0]   q0_r, q1_r, q2_r, q3_r;
  logic [PW-1:0]    ex2_r;
  logic             or2_r;
  logic             en1_s, en2_s, en3_s, xfer_s;
  logic [PW-1:0]    t0_s, t1_s, t2_s, t3_s, r_s, err_s;
  logic [EW-1:0]    sum_ext_s;
  logic [SUM_W-1:0] sum_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [PW-1:0]    max_nxt_s;

  // Stall chain runs combinationally back from out_ready.
  assign en3_s     = ~v3_r | out_ready;
  assign en2_s     = ~v2_r | en3_s;
  assign en1_s     = ~v1_r | en2_s;
  assign in_ready  = en1_s;
  assign out_valid = v3_r;
  assign xfer_s    = v3_r & out_ready;

  // Stage 1: capture operands together with their configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      a1_r   <= {WIDTH{1'b0}};
      b1_r   <= {WIDTH{1'b0}};
      cfg1_r <= 9'h000;
    end else if (en1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        a1_r   <= in_a;
        b1_r   <= in_b;
        cfg1_r <= in_cfg;
      end
    end
  end

  // Stage 2: mode-adjusted quadrant products alongside the exact product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r  <= 1'b0;
      q0_r  <= {(2*H){1'b0}};
      q1_r  <= {(2*H){1'b0}};
      q2_r  <= {(2*H){1'b0}};
      q3_r  <= {(2*H){1'b0}};
      ex2_r <= {PW{1'b0}};
      or2_r <= 1'b0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        q0_r  <= quad(a1_r[H-1:0],     b1_r[H-1:0],     cfg1_r[1:0]);
        q1_r  <= quad(a1_r[H-1:0],     b1_r[WIDTH-1:H], cfg1_r[3:2]);
        q2_r  <= quad(a1_r[WIDTH-1:H], b1_r[H-1:0],     cfg1_r[5:4]);
        q3_r  <= quad(a1_r[WIDTH-1:H], b1_r[WIDTH-1:H], cfg1_r[7:6]);
        ex2_r <= {{WIDTH{1'b0}}, a1_r} * {{WIDTH{1'b0}}, b1_r};
        or2_r <= cfg1_r[8];
      end
    end
  end

  // Term alignment, recombination and absolute error against the exact product.
  always_comb begin
    t0_s = {{WIDTH{1'b0}}, q0_r};
    t1_s = {{H{1'b0}}, q1_r, {H{1'b0}}};
    t2_s = {{H{1'b0}}, q2_r, {H{1'b0}}};
    t3_s = {q3_r, {WIDTH{1'b0}}};
    if (or2_r) begin
      r_s = t0_s | t1_s | t2_s | t3_s;
    end else begin
      r_s = t0_s + t1_s + t2_s + t3_s;
    end
    if (ex2_r >= r_s) begin
      err_s = ex2_r - r_s;
    end else begin
      err_s = r_s - ex2_r;
    end
  end

  // Stage 3: result registers hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r    <= 1'b0;
      out_r   <= {PW{1'b0}};
      out_err <= {PW{1'b0}};
    end else if (en3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        out_r   <= r_s;
        out_err <= err_s;
      end
    end
  end

  // Saturating next values for the statistics.
  always_comb begin
    sum_ext_s = EW'(stat_sum) + EW'(out_err);
    if (sum_ext_s > EW'(SUM_MAX)) begin
      sum_nxt_s = SUM_MAX;
    end else begin
      sum_nxt_s = sum_ext_s[SUM_W-1:0];
    end
    if (stat_cnt != CNT_MAX) begin
      cnt_nxt_s = stat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = stat_cnt;
    end
    if (out_err > stat_max) begin
      max_nxt_s = out_err;
    end else begin
      max_nxt_s = stat_max;
    end
  end

  // Statistics registers; a clear takes priority over a coincident transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= {CNT_W{1'b0}};
      stat_max <= {PW{1'b0}};
      stat_sum <= {SUM_W{1'b0}};
    end else if (stat_clr) begin
      stat_cnt <= {CNT_W{1'b0}};
      stat_max <= {PW{1'b0}};
      stat_sum <= {SUM_W{1'b0}};
    end else if (xfer_s) begin
      stat_cnt <= cnt_nxt_s;
      stat_max <= max_nxt_s;
      stat_sum <= sum_nxt_s;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe_cfg.sv
// Self-checking bench for approx_mult_pipe_cfg: directed plan vectors, backpressure,
// randomized traffic against an arithmetic reference model, clear and reset cases.
module tb_approx_mult_pipe_cfg;

  localparam int W  = 8;
  localparam int TR = 2;
  localparam int CW = 16;
  localparam int SW = 32;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [W-1:0]   in_a, in_b;
  logic [8:0]     in_cfg;
  logic [2*W-1:0] out_r, out_err, stat_max;
  logic [CW-1:0]  stat_cnt;
  logic [SW-1:0]  stat_sum;

  int errors = 0;
  int checks = 0;

  typedef struct { int r; int e; } res_t;
  res_t   exp_q[$];
  longint m_cnt, m_sum, m_max;

  approx_mult_pipe_cfg #(.WIDTH(W), .TRUNC(TR), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cfg(in_cfg), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_err(out_err), .stat_clr(stat_clr),
    .stat_cnt(stat_cnt), .stat_max(stat_max), .stat_sum(stat_sum)
  );

  always #5 clk = ~clk;

  // Reference: split operands by division, approximate each quadrant, recombine.
  function automatic void ref_calc(input int a, input int b, input int cfg,
                                   output int r, output int e);
    int hv, x, y, p, t, sum, orv, ex;
    hv = 1 << (W / 2);
    sum = 0;
    orv = 0;
    for (int k = 0; k < 4; k++) begin
      x = (k >= 2) ? a / hv : a % hv;
      y = (k % 2 == 1) ? b / hv : b % hv;
      case ((cfg >> (2 * k)) % 4)
        0: p = x * y;
        1: p = (TR >= W) ? 0 : x * y - (x * y) % (1 << TR);
        2: p = (x - x % 2) * (y - y % 2);
        default: p = 0;
      endcase
      t = p * ((k == 0) ? 1 : (k == 3) ? hv * hv : hv);
      sum += t;
      orv |= t;
    end
    r = ((cfg >> 8) % 2 == 1) ? orv : sum % (1 << (2 * W));
    ex = a * b;
    e = (ex > r) ? ex - r : r - ex;
  endfunction

  // One clock: observe handshakes at negedge, keep scoreboard and stats model.
  task automatic step(output bit acc, output bit xfer, output logic [31:0] gr,
                      output logic [31:0] ge, output int er, output int ee);
    int   rr, re;
    res_t x;
    @(negedge clk);
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    gr   = {16'h0000, out_r};
    ge   = {16'h0000, out_err};
    er   = -1;
    ee   = -1;
    if (acc) begin
      ref_calc(int'(in_a), int'(in_b), int'(in_cfg), rr, re);
      exp_q.push_back('{rr, re});
    end
    if (xfer && exp_q.size() > 0) begin
      x  = exp_q.pop_front();
      er = x.r;
      ee = x.e;
    end
    if (stat_clr) begin
      m_cnt = 0; m_sum = 0; m_max = 0;
    end else if (xfer && ee >= 0) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      m_sum = m_sum + ee;
      if (m_sum > 64'd4294967295) m_sum = 64'd4294967295;
      if (ee > m_max) m_max = ee;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_cfg = 9'h000;
    m_cnt = 0; m_sum = 0; m_max = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_r !== 16'h0000) begin errors++; $display("FAIL reset_out_r got=%h exp=0000", out_r); end
    checks++; if (out_err !== 16'h0000) begin errors++; $display("FAIL reset_out_err got=%h exp=0000", out_err); end
    checks++; if (stat_cnt !== 16'h0000 || stat_max !== 16'h0000 || stat_sum !== 32'h0)
      begin errors++; $display("FAIL reset_stats got=%h/%h/%h exp=0", stat_cnt, stat_max, stat_sum); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0]  ta[5]  = '{8'hFF, 8'h11, 8'h0F, 8'h10, 8'h03};
    logic [7:0]  tb_[5] = '{8'hFF, 8'h11, 8'h0F, 8'h10, 8'h03};
    logic [8:0]  tc[5]  = '{9'h000, 9'h100, 9'h001, 9'h0C0, 9'h000};
    logic [15:0] tr[5]  = '{16'hFE01, 16'h0111, 16'h00E0, 16'h0000, 16'h0009};
    logic [15:0] te[5]  = '{16'h0000, 16'h0010, 16'h0001, 16'h0100, 16'h0000};
    bit          clr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit acc, xfer;
    logic [31:0] gr, ge;
    int er, ee, lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (clr[i]) begin
        stat_clr = 1'b1;
        step(acc, xfer, gr, ge, er, ee);
        stat_clr = 1'b0;
      end
      in_valid = 1'b1; in_a = ta[i]; in_b = tb_[i]; in_cfg = tc[i];
      step(acc, xfer, gr, ge, er, ee);
      in_valid = 1'b0;
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        step(acc, xfer, gr, ge, er, ee);
        if (xfer) begin
          lat = n;
          checks++; if (gr !== {16'h0000, tr[i]}) begin errors++; $display("FAIL dir%0d_out_r got=%h exp=%h", i, gr, tr[i]); end
          checks++; if (ge !== {16'h0000, te[i]}) begin errors++; $display("FAIL dir%0d_out_err got=%h exp=%h", i, ge, te[i]); end
          checks++; if (gr !== er || ge !== ee) begin errors++; $display("FAIL dir%0d_model got=%h/%h exp=%h/%h", i, gr, ge, er, ee); end
          break;
        end
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=3", i, lat); end
      checks++; if (stat_cnt !== CW'(m_cnt) || stat_max !== 16'(m_max) || stat_sum !== SW'(m_sum))
        begin errors++; $display("FAIL dir%0d_stats got=%h/%h/%h exp=%h/%h/%h", i, stat_cnt, stat_max, stat_sum, m_cnt, m_max, m_sum); end
      if (i == 0) begin
        checks++; if (stat_cnt !== 16'd1 || stat_max !== 16'h0000)
          begin errors++; $display("FAIL dir_exact_stats got=%h/%h exp=0001/0000", stat_cnt, stat_max); end
      end else if (i == 1) begin
        checks++; if (stat_sum !== 32'h10) begin errors++; $display("FAIL dir_or_sum got=%h exp=10", stat_sum); end
      end else if (i == 4) begin
        checks++; if (stat_max !== 16'h0100 || stat_cnt !== 16'd2)
          begin errors++; $display("FAIL dir_gate_stats got=%h/%h exp=0100/0002", stat_max, stat_cnt); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[5], bb[5];
    logic [8:0] bc[5];
    logic [15:0] held;
    bit acc, xfer;
    logic [31:0] gr, ge;
    int er, ee, k;
    for (int i = 0; i < 5; i++) begin
      ba[i] = 8'(16 * i + 1 + $urandom_range(0, 14));
      bb[i] = 8'($urandom);
      bc[i] = 9'($urandom);
    end
    out_ready = 1'b0;
    k = 0;
    held = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = ba[k]; in_b = bb[k]; in_cfg = bc[k];
      step(acc, xfer, gr, ge, er, ee);
      if (acc) k++;
      if (c == 4) held = out_r;
    end
    checks++; if (k != 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_r !== held)
      begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_r, held); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (k < 5) begin
        in_valid = 1'b1; in_a = ba[k]; in_b = bb[k]; in_cfg = bc[k];
      end else begin
        in_valid = 1'b0;
      end
      step(acc, xfer, gr, ge, er, ee);
      if (acc) k++;
      checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL bp_consecutive%0d got=%b exp=1", c, xfer); end
      if (xfer) begin
        checks++; if (gr !== er || ge !== ee)
          begin errors++; $display("FAIL bp_order%0d got=%h/%h exp=%h/%h", c, gr, ge, er, ee); end
      end
    end
    in_valid = 1'b0;
    checks++; if (k != 5) begin errors++; $display("FAIL bp_total got=%0d exp=5", k); end
  endtask

  task automatic test_random();
    bit acc, xfer;
    logic [31:0] gr, ge;
    int er, ee;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_cfg    = 9'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      stat_clr  = ($urandom_range(0, 39) == 0);
      step(acc, xfer, gr, ge, er, ee);
      if (xfer) begin
        checks++; if (gr !== er || ge !== ee)
          begin errors++; $display("FAIL rnd_result cyc=%0d got=%h/%h exp=%h/%h", c, gr, ge, er, ee); end
      end
    end
    in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(acc, xfer, gr, ge, er, ee);
      if (xfer) begin
        checks++; if (gr !== er || ge !== ee)
          begin errors++; $display("FAIL rnd_drain got=%h/%h exp=%h/%h", gr, ge, er, ee); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
    checks++; if (stat_cnt !== CW'(m_cnt) || stat_max !== 16'(m_max) || stat_sum !== SW'(m_sum))
      begin errors++; $display("FAIL rnd_stats got=%h/%h/%h exp=%h/%h/%h", stat_cnt, stat_max, stat_sum, m_cnt, m_max, m_sum); end
  endtask

  task automatic test_clr_xfer();
    bit acc, xfer;
    logic [31:0] gr, ge;
    int er, ee;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h10; in_cfg = 9'h0C0;
    step(acc, xfer, gr, ge, er, ee);
    in_valid = 1'b0;
    step(acc, xfer, gr, ge, er, ee);
    step(acc, xfer, gr, ge, er, ee);
    stat_clr = 1'b1;
    step(acc, xfer, gr, ge, er, ee);
    stat_clr = 1'b0;
    checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL clr_xfer_happened got=%b exp=1", xfer); end
    checks++; if (stat_cnt !== 16'h0000 || stat_sum !== 32'h0 || stat_max !== 16'h0000)
      begin errors++; $display("FAIL clr_wins got=%h/%h/%h exp=0", stat_cnt, stat_max, stat_sum); end
  endtask

  task automatic test_reset_mid();
    bit acc, xfer;
    logic [31:0] gr, ge;
    int er, ee, stale;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h10; in_cfg = 9'h0C0;
    step(acc, xfer, gr, ge, er, ee);
    in_valid = 1'b0;
    repeat (4) step(acc, xfer, gr, ge, er, ee);
    checks++; if (stat_cnt !== 16'd1 || stat_sum !== 32'h100)
      begin errors++; $display("FAIL rm_pre_stats got=%h/%h exp=0001/00000100", stat_cnt, stat_sum); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h21; in_b = 8'h43; in_cfg = 9'h000;
    step(acc, xfer, gr, ge, er, ee);
    in_a = 8'h65; in_b = 8'h87;
    step(acc, xfer, gr, ge, er, ee);
    in_valid = 1'b0;
    step(acc, xfer, gr, ge, er, ee);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_inflight got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
    checks++; if (stat_cnt !== 16'h0000 || stat_max !== 16'h0000 || stat_sum !== 32'h0)
      begin errors++; $display("FAIL rm_stats got=%h/%h/%h exp=0", stat_cnt, stat_max, stat_sum); end
    exp_q.delete();
    m_cnt = 0; m_sum = 0; m_max = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      step(acc, xfer, gr, ge, er, ee);
      if (xfer) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rm_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_clr_xfer();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
